serial_sub_ctrl: RTL
====================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the minuend and the subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit: the borrow-in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: the difference.
REQ-011 The block SHALL have port borrow, output, 1 bit: the final borrow-out.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL compute {borrow, diff} = a - b - bin, one 4-bit nibble per cycle, LSB nibble first, using a single shared 4-bit subtract cell.
REQ-014 The FSM SHALL have three states:
- IDLE: in_ready = 1.
- CALC: processes nibble k and updates the borrow register.
- DONE: out_valid = 1.
REQ-015 An input handshake (in_valid & in_ready in IDLE) SHALL do all of the following:
- register a, b and bin;
- clear the nibble counter;
- enter CALC.
REQ-016 In CALC the counter SHALL advance each cycle; after the cycle processing nibble NUM_NIB-1 (NUM_NIB = WIDTH/4) the FSM SHALL enter DONE.
REQ-017 Latency SHALL be exactly NUM_NIB+1 cycles from the input handshake edge to out_valid high.
REQ-018 In DONE, diff and borrow SHALL stay stable until the output handshake (out_valid & out_ready); the FSM SHALL then return to IDLE, with in_ready high the next cycle.
REQ-019 in_ready SHALL be 0 in CALC and DONE; in_valid asserted there SHALL be ignored and SHALL NOT alter captured operands.
REQ-020 Changes on a, b or bin after capture SHALL NOT affect the result.
REQ-021 Without saturation, wrap-around SHALL be modulo 2^WIDTH, with borrow = 1 whenever a < b + bin (unsigned).
REQ-022 With out_ready held high, throughput SHALL be one operation per NUM_NIB+2 cycles.
REQ-023 diff and borrow SHALL retain their last value in IDLE and CALC until overwritten by the next completion.

Reset
REQ-024 On rst_n low, regardless of clk and mid-operation, the block SHALL:
- enter IDLE;
- clear the counter, the operand registers and the borrow register;
- drive diff = 0, borrow = 0, out_valid = 0 and busy = 0.
REQ-025 in_ready SHALL be 1 during reset and in the first cycle after reset release; an aborted operation SHALL produce no out_valid.

Configuration
REQ-026 With macro SERIAL_SUB_SAT_EN defined, a completion with final borrow = 1 SHALL force diff to 0 while still reporting borrow = 1.
REQ-027 Without SERIAL_SUB_SAT_EN, diff SHALL be the wrapped result per REQ-021; latency and handshake SHALL be identical in both builds.

Structure
REQ-028 A shared package serial_sub_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and a NUM_NIB calculation function.
REQ-029 The 4-bit subtract-with-borrow cell SHALL be a separate sub-module, sub4_cell (inputs a4, b4, bi; outputs d4, bo), instantiated once.
REQ-030 An elaboration-time check SHALL reject a WIDTH that is not a multiple of 4 or is below 4.

Verification (WIDTH = 16)
REQ-031 a=0x1234, b=0x0234, bin=0 -> diff=0x1000, borrow=0, out_valid exactly 5 cycles after the handshake.
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, borrow=1; with SERIAL_SUB_SAT_EN: diff=0x0000, borrow=1.
REQ-033 a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, borrow=1 (0x0000 with SERIAL_SUB_SAT_EN); a=0xFFFF, b=0x0000, bin=1 -> diff=0xFFFE, borrow=0.
REQ-034 Hold out_ready low 3 cycles in DONE -> diff/borrow stable and in_ready=0 throughout; a new in_valid pulse with a=0xAAAA is ignored; the result is accepted on the first out_ready cycle.
REQ-035 Assert rst_n low for 1 cycle during CALC nibble 2 -> all outputs reset per REQ-024, no out_valid appears, and a following operation 0x8000-0x0001 returns 0x7FFF, borrow=0.
REQ-036 Back-to-back operations with out_ready=1 -> a new result every 6 cycles, each matching a reference a-b-bin model over 200 random operand sets.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and nibble-count helper for serial_sub_ctrl
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_nib(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/sub4_cell.sv
// rtl/sub4_cell.sv - 4-bit subtract-with-borrow cell: {bo, d4} = a4 - b4 - bi
module sub4_cell (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       bi,
  output logic [3:0] d4,
  output logic       bo
);

  // 5-bit difference spans -16..15, so bit 4 is set exactly when the result is negative
  logic [4:0] full;

  assign full = {1'b0, a4} - {1'b0, b4} - {4'b0000, bi};
  assign d4   = full[3:0];
  assign bo   = full[4];

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - nibble-serial a - b - bin with valid/ready handshakes
// Optional macro SERIAL_SUB_SAT_EN: a negative result reports diff = 0 with borrow = 1.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int NUM_NIB = num_nib(WIDTH);
  localparam int CW      = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("serial_sub_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt, fin, diff_q;
  logic             br_q, borrow_q;
  logic [3:0]       a4, b4, d4;
  logic             bo;
  logic             last, in_fire, out_fire;

  assign last     = (cnt == CW'(NUM_NIB - 1));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign a4 = a_q[{cnt, 2'b00} +: 4];
  assign b4 = b_q[{cnt, 2'b00} +: 4];

  sub4_cell u_cell (
    .a4 (a4),
    .b4 (b4),
    .bi (br_q),
    .d4 (d4),
    .bo (bo)
  );

  always_comb begin
    res_nxt = res_q;
    res_nxt[{cnt, 2'b00} +: 4] = d4;
  end

`ifdef SERIAL_SUB_SAT_EN
  assign fin = bo ? '0 : res_nxt;
`else
  assign fin = res_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire)  state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Partial nibbles build up in res_q; diff only changes when the last nibble lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (in_fire) begin
      a_q  <= a;
      b_q  <= b;
      br_q <= bin;
      cnt  <= '0;
    end else if (state == CALC) begin
      cnt   <= last ? '0 : cnt + CW'(1);
      br_q  <= bo;
      res_q <= res_nxt;
      if (last) begin
        diff_q   <= fin;
        borrow_q <= bo;
      end
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
